// File: rtl/mux_arbiter_pkg.sv
// rtl/mux_arbiter_pkg.sv - shared types and constants for the round-robin mux arbiter
// Purpose : FSM state encoding, requester count, transfer-counter width.
// Ports   : none (package).
package mux_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int N_REQ_C    = 4;
  localparam int IDX_W      = 2;
  localparam int XFER_CNT_W = 8;

  localparam logic [XFER_CNT_W-1:0] CNT_ONE = XFER_CNT_W'(1);

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rtl/mux_arbiter_rr_pick.sv - combinational round-robin winner search over four requesters
// Purpose : pick the first set request bit searching upward from (last+1) mod 4.
// Ports   : req    - request vector
//           last   - index of the most recently served requester
//           any    - at least one request is set
//           idx    - binary index of the winner (0 when none)
//           onehot - one-hot winner (all-zero when none)
module rr_pick
  import mux_arbiter_pkg::*;
(
  input  logic [N_REQ_C-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any,
  output logic [IDX_W-1:0]   idx,
  output logic [N_REQ_C-1:0] onehot
);

  always_comb begin
    logic [IDX_W-1:0] v_cand;
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    v_cand = '0;
    // Offset N_REQ_C wraps back onto last itself, so the just-served
    // requester is considered only after every other one.
    for (int k = 1; k <= N_REQ_C; k++) begin
      v_cand = last + IDX_W'(k);
      if (!any && req[v_cand]) begin
        any = 1'b1;
        idx = v_cand;
      end
    end
    if (any) begin
      onehot = N_REQ_C'(1) << idx;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin 4:1 arbiter with registered mux output and ready handshake
// Purpose : grants one of four requesters, latches its lane, holds it until ready_in,
//           re-arbitrates on completion with the served requester at lowest priority.
// Ports   : clk, reset_L          - clock, async active-low reset
//           req, data_in          - request bits and packed data lanes
//           ready_in              - downstream acceptance
//           grant, sel, data_out  - registered one-hot grant, index, captured lane
//           valid_out             - data_out holds an untransferred word
//           xfer_cnt              - completed transfer count (wraps)
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  input  logic                   ready_in,
  output logic [N_REQ-1:0]       grant,
  output logic [IDX_W-1:0]       sel,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic [XFER_CNT_W-1:0]  xfer_cnt
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [N_REQ-1:0]      r_grant;
  logic [IDX_W-1:0]      r_sel;
  logic [WIDTH-1:0]      r_data;
  logic [IDX_W-1:0]      r_last;
  logic [XFER_CNT_W-1:0] r_cnt;

  logic                  w_done;
  logic [IDX_W-1:0]      w_last_eff;
  logic                  w_any;
  logic [IDX_W-1:0]      w_idx;
  logic [N_REQ-1:0]      w_onehot;
  logic                  w_load;
  logic [WIDTH-1:0]      w_lane;

  assign w_done     = (r_state == HOLD) && ready_in;
  // On completion the search must already see the updated pointer.
  assign w_last_eff = w_done ? r_sel : r_last;
  assign w_load     = w_any && ((r_state == IDLE) || w_done);
  assign w_lane     = data_in[w_idx*WIDTH +: WIDTH];

  rr_pick u_rr_pick (
    .req    (req),
    .last   (w_last_eff),
    .any    (w_any),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_any) w_state_nxt = HOLD;
      HOLD: if (w_done && !w_any) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    valid_out = (r_state == HOLD);
  end

  // Grant / datapath registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_grant <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_last  <= IDX_W'(N_REQ_C - 1);
      r_cnt   <= '0;
    end else begin
      if (w_done) begin
        r_last <= r_sel;
        r_cnt  <= r_cnt + CNT_ONE;
      end
      if (w_load) begin
        r_grant <= w_onehot;
        r_sel   <= w_idx;
        r_data  <= w_lane;
      end else if (w_done) begin
        // Dropping to IDLE: sel and data_out keep the last word.
        r_grant <= '0;
      end
    end
  end

  assign grant    = r_grant;
  assign sel      = r_sel;
  assign data_out = r_data;
  assign xfer_cnt = r_cnt;

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of each requester lane and of data_out.
REQ-002 Parameter N_REQ, default 4, SHALL set the requester count; only the value 4 is supported.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_L, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port req, input, N_REQ, SHALL carry one request bit per requester.
REQ-006 Port data_in, input, N_REQ*WIDTH, SHALL carry the packed lanes; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port ready_in, input, 1, SHALL be the downstream acceptance signal.
REQ-008 Port grant, output, N_REQ, SHALL be a registered one-hot grant, or all-zero when no requester is granted.
REQ-009 Port sel, output, 2, SHALL be the registered binary index of the granted lane, i.e. the mux select.
REQ-010 Port data_out, output, WIDTH, SHALL be the registered copy of the granted lane.
REQ-011 Port valid_out, output, 1, SHALL indicate that data_out holds an untransferred word.
REQ-012 Port xfer_cnt, output, 8, SHALL count completed transfers.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE (valid_out=0) and HOLD (valid_out=1).
REQ-014 In IDLE with req!=0 at edge k, the block SHALL set grant, sel, data_out and valid_out=1 at edge k+1 and enter HOLD.
REQ-015 Grant latency from req to valid_out SHALL be exactly one cycle.
REQ-016 The winner SHALL be chosen round-robin: the first requester with req set, searching from index (last+1) mod 4 upward.
REQ-017 last SHALL be an internal 2-bit pointer holding the index of the most recently completed transfer.
REQ-018 data_out SHALL be captured at grant time; grant, sel and data_out SHALL stay stable in HOLD while ready_in=0.
REQ-019 A transfer SHALL complete on any edge where valid_out=1 and ready_in=1; on completion, last SHALL be set to sel and xfer_cnt SHALL increment.
REQ-020 xfer_cnt SHALL wrap from 255 to 0.
REQ-021 On completion with req!=0 (the just-served requester included), the next winner SHALL be granted at the same edge, giving back-to-back transfers with valid_out held at 1.
REQ-022 The round-robin search at completion SHALL use the updated last, so the just-served requester has the lowest priority.
REQ-023 On completion with req==0, the block SHALL enter IDLE with grant=0 and valid_out=0; sel and data_out SHALL hold their values.
REQ-024 Deassertion of req by the granted requester during HOLD SHALL NOT cancel the transfer.
REQ-025 ready_in while in IDLE SHALL be ignored.
REQ-026 Changes on data_in after grant SHALL NOT affect data_out until the next grant.

Reset
REQ-027 While reset_L=0, outputs SHALL be: grant=0, sel=0, data_out=0, valid_out=0, xfer_cnt=0.
REQ-028 While reset_L=0, internal state SHALL be: state=IDLE, last=3, so that requester 0 has first priority.
REQ-029 Reset asserted mid-HOLD SHALL immediately abandon the pending word and SHALL NOT increment xfer_cnt.
REQ-030 After reset_L rises, the first grant SHALL occur one edge after req is sampled non-zero.

Structure
REQ-031 A shared package mux_arbiter_pkg SHALL hold the state encoding (IDLE=1'b0, HOLD=1'b1), the N_REQ constant and the xfer_cnt width.
REQ-032 A combinational sub-module rr_pick SHALL take (req, last) and return (any, idx, onehot); mux_arbiter SHALL instantiate it once.
REQ-033 The lane multiplexing SHALL be performed inside mux_arbiter, indexed by the rr_pick result.

Verification
REQ-034 Reset check: reset_L=0 with req=4'b1111 -> all outputs 0; reset_L rises -> at the next edge grant=0001, sel=0, valid_out=1.
REQ-035 Fairness check: req=1111 and ready_in=1 held for 8 cycles -> sel sequence 0,1,2,3,0,1,2,3; xfer_cnt=8.
REQ-036 Backpressure check: lane2=8'hA5, req=0100, ready_in=0 for 5 cycles while lane2 changes to 8'h3C -> data_out stays 8'hA5, grant stays 0100; ready_in=1 -> xfer_cnt increments once.
REQ-037 Drop check: req=0010 for one cycle only, ready_in=1 -> exactly one transfer of lane1 occurs; the block then returns to IDLE with valid_out=0.
REQ-038 Reset-in-HOLD check: valid_out=1, ready_in=0, pulse reset_L low -> valid_out=0 asynchronously and xfer_cnt=0.
REQ-039 Wrap check: 256 completed transfers -> xfer_cnt reads 0; transfer 257 -> xfer_cnt reads 1.
